// File: rtl/golden_nonce_queue_pkg.sv
// ---------------------------------------------------------------------------
// golden_nonce_queue_pkg
// Constants shared by the golden-nonce queue, its interface, and the
// control unit. They cover nonce width, drop-counter width, and the default
// hasher pipeline-latency correction. The package also provides a helper
// that applies that correction.
// ---------------------------------------------------------------------------
package golden_nonce_queue_pkg;

    localparam int          NONCE_W              = 32;
    localparam int          DROP_CNT_W           = 8;
    localparam logic [31:0] DEFAULT_NONCE_OFFSET = 32'd0;

    typedef logic [NONCE_W-1:0]    nonce_t;
    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    // Maps the nonce counter value seen at the hit strobe back to the nonce
    // that actually produced the golden hash. Unsigned subtraction wraps
    // modulo 2^32 with no underflow flag.
    function automatic nonce_t offset_correct(nonce_t raw, nonce_t offset);
        return raw - offset;
    endfunction

endpackage

// File: rtl/golden_nonce_queue_if.sv
// ---------------------------------------------------------------------------
// golden_nonce_queue_if
// This interface groups the producer (hit) signals, the consumer (out)
// handshake signals, and the queue status signals of golden_nonce_queue.
//   master : drives hit, hit_nonce, flush, out_ready
//            (control unit / comm block side)
//   slave  : drives out_valid, out_nonce, level, drop_count (the queue)
// ---------------------------------------------------------------------------
interface golden_nonce_queue_if
    import golden_nonce_queue_pkg::*;
#(
    parameter int DEPTH = 8
) ();

    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic               hit;
    nonce_t             hit_nonce;
    logic               flush;
    logic               out_valid;
    nonce_t             out_nonce;
    logic               out_ready;
    logic [LEVEL_W-1:0] level;
    drop_cnt_t          drop_count;

    modport master (
        output hit, hit_nonce, flush, out_ready,
        input  out_valid, out_nonce, level, drop_count
    );

    modport slave (
        input  hit, hit_nonce, flush, out_ready,
        output out_valid, out_nonce, level, drop_count
    );

endinterface

// File: rtl/golden_nonce_queue_ram.sv
// ---------------------------------------------------------------------------
// nonce_fifo_ram
// DEPTH x NONCE_W storage for the golden-nonce queue. It has a single
// synchronous write port and an asynchronous read port, which maps onto
// distributed RAM.
//   hash_clk : write clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational)
// ---------------------------------------------------------------------------
module nonce_fifo_ram
    import golden_nonce_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          hash_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  nonce_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output nonce_t        o_rdata
);

    nonce_t r_mem [DEPTH];

    // NOTE: the storage array has no reset. Its contents are only read
    // where level says they are valid. A reset branch here would stop the
    // array from mapping onto distributed RAM.
    always_ff @(posedge hash_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/golden_nonce_queue.sv
// ---------------------------------------------------------------------------
// golden_nonce_queue
// This is a first-word-fall-through FIFO of golden nonces found by the
// hasher. Each nonce is corrected by NONCE_OFFSET for pipeline latency
// before it is stored. A hit that arrives while the queue is full is lost
// and counted in a saturating drop counter. A flush (new work) empties the
// queue but keeps the drop count.
//   hash_clk : sole clock, rising edge
//   reset    : synchronous, active-high
//   bus      : golden_nonce_queue_if.slave
//              hit/hit_nonce/flush/out_ready in,
//              out_valid/out_nonce/level/drop_count out
// DEPTH must be a power of two in 2..64, so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module golden_nonce_queue
    import golden_nonce_queue_pkg::*;
#(
    parameter int          DEPTH        = 8,
    parameter logic [31:0] NONCE_OFFSET = DEFAULT_NONCE_OFFSET
) (
    input  logic                   hash_clk,
    input  logic                   reset,
    golden_nonce_queue_if.slave    bus
);

    localparam int AW      = $clog2(DEPTH);
    localparam int LEVEL_W = AW + 1;

    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    drop_cnt_t          r_drop_count;

    logic   w_empty;
    logic   w_full;
    logic   w_pop;
    logic   w_push;
    logic   w_drop;
    nonce_t w_wdata;
    nonce_t w_rdata;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LEVEL_W'(DEPTH));

    // A flush absorbs both sides. A pop frees the slot that a push into a
    // full queue needs in the same cycle. A pop needs a valid head, so
    // out_ready is ignored while the queue is empty.
    assign w_pop   = !w_empty && bus.out_ready && !bus.flush;
    assign w_push  = bus.hit && !bus.flush && (!w_full || w_pop);
    assign w_drop  = bus.hit && !bus.flush && w_full && !w_pop;
    assign w_wdata = offset_correct(bus.hit_nonce, NONCE_OFFSET);

    nonce_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .hash_clk (hash_clk),
        .i_we     (w_push),
        .i_waddr  (r_wr_ptr),
        .i_wdata  (w_wdata),
        .i_raddr  (r_rd_ptr),
        .o_rdata  (w_rdata)
    );

    // NOTE: all state in this block uses non-blocking assignments. Every
    // register then updates from its pre-edge value, whatever the order of
    // the statements.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_drop_count <= '0;
        end else if (bus.flush) begin
            // Drop count survives new work; only the queue contents go.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LEVEL_W'(1);
                2'b01:   r_level <= r_level - LEVEL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + DROP_CNT_W'(1);
            end
        end
    end

    assign bus.out_valid  = !w_empty;
    assign bus.out_nonce  = w_rdata;
    assign bus.level      = r_level;
    assign bus.drop_count = r_drop_count;

endmodule

// File: tb/tb_golden_nonce_queue.sv
// ---------------------------------------------------------------------------
// tb_golden_nonce_queue
// Directed and random stimulus for golden_nonce_queue (DEPTH=8,
// NONCE_OFFSET=2). The reference is a plain queue of corrected nonces plus
// a saturating drop counter.
// ---------------------------------------------------------------------------
module tb_golden_nonce_queue;
    import golden_nonce_queue_pkg::*;

    localparam int          DEPTH  = 8;
    localparam logic [31:0] OFFSET = 32'd2;

    logic hash_clk = 1'b0;
    logic reset    = 1'b0;

    golden_nonce_queue_if #(.DEPTH(DEPTH)) bus ();

    golden_nonce_queue #(
        .DEPTH        (DEPTH),
        .NONCE_OFFSET (OFFSET)
    ) dut (
        .hash_clk (hash_clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 hash_clk = ~hash_clk;

    // Reference model state
    logic [31:0] model_q[$];
    int          model_drops;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compares every visible output against the model.
    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(model_q.size() != 0));
        check({tag, ".level"}, 32'(bus.level), 32'(model_q.size()));
        check({tag, ".drops"}, 32'(bus.drop_count), 32'(model_drops));
        if (model_q.size() != 0) begin
            check({tag, ".nonce"}, bus.out_nonce, model_q[0]);
        end
    endtask

    // One clock cycle. Inputs are applied just after an edge; the model
    // advances on the pre-edge view; outputs are checked 1 time unit after
    // the next edge.
    task automatic step(input bit h, input logic [31:0] n, input bit f, input bit r,
                        input string tag);
        bit was_full;
        bit popped;
        bus.hit       = h;
        bus.hit_nonce = n;
        bus.flush     = f;
        bus.out_ready = r;
        if (f) begin
            model_q.delete();
        end else begin
            was_full = (model_q.size() == DEPTH);
            popped   = (model_q.size() != 0) && r;
            if (popped) void'(model_q.pop_front());
            if (h) begin
                if (was_full && !popped) begin
                    if (model_drops < 255) model_drops++;
                end else begin
                    model_q.push_back(n - OFFSET);
                end
            end
        end
        @(posedge hash_clk);
        #1;
        check_all(tag);
    endtask

    // Reset with random noise on the other inputs, since reset dominates.
    task automatic do_reset(input string tag);
        reset         = 1'b1;
        bus.hit       = 1'($urandom);
        bus.hit_nonce = $urandom;
        bus.flush     = 1'($urandom);
        bus.out_ready = 1'($urandom);
        model_q.delete();
        model_drops = 0;
        @(posedge hash_clk);
        #1;
        reset = 1'b0;
        check_all(tag);
    endtask

    initial begin
        bus.hit       = 1'b0;
        bus.hit_nonce = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        model_drops   = 0;

        // Reset state
        do_reset("reset0");
        do_reset("reset1");

        // Single hit, held with out_ready=0
        step(1, 32'h0000_0105, 0, 0, "hit105");
        check("hit105.exact", bus.out_nonce, 32'h0000_0103);
        for (int i = 0; i < 5; i++) step(0, $urandom, 0, 0, "hold");
        check("hold.exact", bus.out_nonce, 32'h0000_0103);

        // Modular wrap below zero
        step(0, '0, 1, 1, "flush_a");
        step(1, 32'h0000_0001, 0, 0, "wrap");
        check("wrap.exact", bus.out_nonce, 32'hFFFF_FFFF);

        // Overfill: 10 hits into an empty queue, then drain in order
        step(0, '0, 1, 0, "flush_b");
        for (int i = 0; i < 10; i++) step(1, 32'h1000 + 32'(i), 0, 0, "fill10");
        check("fill10.level", 32'(bus.level), 32'd8);
        check("fill10.drops", 32'(bus.drop_count), 32'd2);
        for (int i = 0; i < 8; i++) begin
            check("drain.order", bus.out_nonce, 32'h1000 + 32'(i) - OFFSET);
            step(0, '0, 0, 1, "drain");
        end
        check("drain.empty", 32'(bus.out_valid), 32'd0);
        step(0, '0, 0, 1, "ready_empty");

        // Full queue with simultaneous push and pop
        for (int i = 0; i < 8; i++) step(1, 32'h2000 + 32'(i), 0, 0, "fill8");
        step(1, 32'h2ABC, 0, 1, "full_pushpop");
        check("full_pushpop.level", 32'(bus.level), 32'd8);
        check("full_pushpop.drops", 32'(bus.drop_count), 32'd2);
        check("full_pushpop.head", bus.out_nonce, 32'h2001 - OFFSET);
        for (int i = 0; i < 8; i++) step(0, '0, 0, 1, "drain2");
        check("drain2.last", 32'(bus.out_valid), 32'd0);

        // Flush beats a same-cycle hit
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0, "fill3");
        step(1, 32'h3333, 1, 1, "flush_hit");
        check("flush_hit.level", 32'(bus.level), 32'd0);
        check("flush_hit.drops", 32'(bus.drop_count), 32'd2);

        // Empty with push and pop in the same cycle
        step(1, 32'h4444, 0, 1, "empty_pushpop");
        check("empty_pushpop.level", 32'(bus.level), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 60), $urandom, ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 45), "rand");
        end

        // Mid-stream reset, then the first hit is the sole entry
        do_reset("reset_mid");
        step(1, 32'h5555_0000, 0, 0, "post_reset");
        check("post_reset.level", 32'(bus.level), 32'd1);
        check("post_reset.head", bus.out_nonce, 32'h5554_FFFE);

        // Drop counter saturation, then reset clears it
        for (int i = 0; i < 310; i++) step(1, $urandom, 0, 0, "sat");
        check("sat.drops", 32'(bus.drop_count), 32'd255);
        check("sat.level", 32'(bus.level), 32'd8);
        do_reset("reset_sat");
        check("reset_sat.drops", 32'(bus.drop_count), 32'd0);
        check("reset_sat.level", 32'(bus.level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
